// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and decode helpers for the M-extension sequencer.
// The op code values are also used by the ALU decoder.
package muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'b01010;
  localparam logic [4:0] OP_MULH   = 5'b01011;
  localparam logic [4:0] OP_MULHSU = 5'b01100;
  localparam logic [4:0] OP_MULHU  = 5'b01101;
  localparam logic [4:0] OP_DIV    = 5'b01110;
  localparam logic [4:0] OP_DIVU   = 5'b01111;
  localparam logic [4:0] OP_REM    = 5'b10000;
  localparam logic [4:0] OP_REMU   = 5'b10001;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  function automatic logic is_mul(input logic [4:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // True when op1 is interpreted as a signed value.
  function automatic logic is_signed(input logic [4:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_rem(input logic [4:0] op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // Divide by zero, or the one signed quotient that does not fit in 32 bits.
  function automatic logic div_special_case(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    return (b == 32'd0) ||
           (is_signed(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] div_special_result(input logic [4:0] op,
                                                     input logic [31:0] a,
                                                     input logic [31:0] b);
    if (b == 32'd0) return is_rem(op) ? a : 32'hFFFF_FFFF;
    return is_rem(op) ? 32'd0 : 32'h8000_0000;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the mul/div sequencer.
// master = pipeline side, slave = sequencer side.
interface muldiv_seq_if #(parameter int DATA_WIDTH = 32);
  logic                  start;
  logic [4:0]            op;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  flush;
  logic                  busy;
  logic                  stall;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (output start, op, op1, op2, flush,
                  input  busy, stall, done, result);
  modport slave  (input  start, op, op1, op2, flush,
                  output busy, stall, done, result);
endinterface

// File: rtl/muldiv_seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
// Purely combinational; the caller keeps the partial remainder below the divisor.
module div_step (
  input  logic [32:0] rem_in,
  input  logic        bit_in,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [33:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = shifted >= {2'b00, divisor};
  assign rem_out = q_bit ? 33'(shifted - {2'b00, divisor}) : 33'(shifted);

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle sequencer: mul done 2 cycles after accept, div/rem 34 (1 for special cases with
// MULDIV_BYPASS_EN defined). Holds the pipeline via stall until the DONE cycle; flush aborts silently.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  muldiv_seq_if.slave     bus
);

  state_t                state;
  logic [4:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [32:0]           rem_q;
  logic [31:0]           quo_q;
  logic [31:0]           dvsr_q;
  logic [4:0]            cnt;
  logic                  q_neg;
  logic                  r_neg;
  logic [DATA_WIDTH-1:0] result_q;

  logic        accept;
  logic        sgn_in;
  logic [32:0] rem_nx;
  logic        q_bit;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic [31:0] fix_result;

  assign accept = (state == IDLE) && bus.start && !bus.flush &&
                  (is_mul(bus.op) || is_div(bus.op));
  assign sgn_in = is_signed(bus.op);

  assign bus.busy   = (state != IDLE);
  assign bus.stall  = accept || (state inside {MUL, DIV, FIX});
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

  div_step u_div_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[31]),
    .divisor (dvsr_q),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  // 64-bit extension of 33-bit sign/zero-extended operands; the low 64 product bits are exact.
  always_comb begin
    mul_a = {{32{is_signed(op_q) & a_q[31]}}, a_q};
    mul_b = {{32{(op_q == OP_MUL || op_q == OP_MULH) & b_q[31]}}, b_q};
    prod  = mul_a * mul_b;
  end

  always_comb begin
    fix_result = q_neg ? -quo_q : quo_q;
    if (div_special_case(op_q, a_q, b_q))
      fix_result = div_special_result(op_q, a_q, b_q);
    else if (is_rem(op_q))
      fix_result = r_neg ? -rem_q[31:0] : rem_q[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= bus.op;
            a_q    <= bus.op1;
            b_q    <= bus.op2;
            rem_q  <= '0;
            cnt    <= 5'd31;
            quo_q  <= (sgn_in && bus.op1[31]) ? -bus.op1 : bus.op1;
            dvsr_q <= (sgn_in && bus.op2[31]) ? -bus.op2 : bus.op2;
            q_neg  <= sgn_in & (bus.op1[31] ^ bus.op2[31]);
            r_neg  <= sgn_in & bus.op1[31];
            if (is_mul(bus.op)) state <= MUL;
            else                state <= DIV;
`ifdef MULDIV_BYPASS_EN
            if (is_div(bus.op) && div_special_case(bus.op, bus.op1, bus.op2)) begin
              result_q <= div_special_result(bus.op, bus.op1, bus.op2);
              state    <= DONE;
            end
`endif
          end
        end
        MUL: begin
          result_q <= (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
          state    <= DONE;
        end
        DIV: begin
          // Dividend bits leave quo_q at the top while quotient bits enter at the bottom.
          rem_q <= rem_nx;
          quo_q <= {quo_q[30:0], q_bit};
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end
        FIX: begin
          result_q <= fix_result;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide operations that the single-cycle ALU cannot close timing on. It sits beside the ALU in the execute stage. It accepts one M-extension operation at a time using the ALU's 5-bit operation codes, stalls the pipeline while it works, and returns the 32-bit result with a one-cycle done pulse. Multiplies use a registered single-pass product. Divides and remainders use a 32-step restoring iteration.

## Interface
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled with op/op1/op2 on the rising edge.
- op  in  5  operation code: 01010 MUL, 01011 MULH, 01100 MULHSU, 01101 MULHU, 01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU.
- op1  in  32  rs1 operand (dividend / multiplicand).
- op2  in  32  rs2 operand (divisor / multiplier).
- flush  in  1  abort any in-flight operation.
- busy  out  1  high whenever state ≠ IDLE.
- stall  out  1  combinational pipeline hold.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  32  registered result; holds its value until the next completion.

## Operation
- States are IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start with a valid op (codes listed above) and flush low is accepted.
  - Multiply ops go to MUL. Divide/remainder ops go to DIV.
  - Any other op code is ignored and the block stays in IDLE.
  - On acceptance, op, op1 and op2 are latched internally. Later input changes have no effect.
- MUL: forms a 64-bit product.
  - MUL and MULH: signed × signed.
  - MULHSU: signed op1 × unsigned op2, using 33-bit sign/zero extension.
  - MULHU: unsigned × unsigned.
  - MUL returns bits [31:0]; the other three return bits [63:32].
  - Always moves to DONE next cycle.
- DIV: restoring division on magnitudes. Signed ops take absolute values at acceptance; unsigned ops use raw operands.
  - One quotient bit per cycle, MSB first.
  - A 5-bit step counter counts 31 down to 0. The FSM moves to FIX after the step with counter = 0, i.e. 32 cycles in DIV.
- FIX: applies signs and writes result.
  - DIV: quotient is negated if operand signs differ.
  - REM: remainder takes the sign of the dividend.
  - Unsigned ops: no sign correction.
  - Moves to DONE.
- DONE: done = 1 and result is valid. Returns to IDLE next cycle. start in DONE is ignored.
- Special cases (RISC-V M semantics):
  - Divide by zero: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = op1.
  - Signed overflow (op1 = 0x80000000, op2 = 0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- stall = (state == IDLE & start & valid op & !flush) | state ∈ {MUL, DIV, FIX}. stall is low in DONE so the pipeline captures the result.
- flush: from any state, the next state is IDLE.
  - No done pulse is generated and result is left unchanged.
  - flush beats start when both arrive in the same cycle, and beats completion.
- Reset: state = IDLE, busy = 0, done = 0, result = 0, counter = 0. Reset mid-operation discards the operation with no done pulse.

## Timing
- Latency is counted from the accepting edge (cycle 0) to the cycle where done is high.
- Multiply: done in cycle 2.
- Divide/remainder: done in cycle 34 (32 DIV cycles + FIX + DONE).
- With MULDIV_BYPASS_EN (see Configuration), special-case divides complete with done in cycle 1.
- Back-to-back: the earliest next accept is the cycle after DONE, i.e. IDLE at cycle 3 (mul) or 35 (div).
- busy is high from cycle 1 through the DONE cycle inclusive.

## Configuration
- MULDIV_BYPASS_EN defined: divide-by-zero and signed-overflow cases are detected at acceptance. The FSM goes IDLE → DONE directly, with the special-case result registered on the accepting edge.
- MULDIV_BYPASS_EN undefined: these cases run the full 32-step iteration and FIX applies the special-case result. Results are identical; only latency differs.

## Structure
- Package muldiv_pkg holds:
  - localparams for the eight op codes, shared with the ALU decoder;
  - the state enum {IDLE, MUL, DIV, FIX, DONE};
  - helper predicates is_mul(op), is_div(op), is_signed(op), is_rem(op).
- Sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder (33 bits), next dividend bit, divisor.
  - Outputs: new partial remainder and quotient bit.
  - Instantiated once and reused every DIV cycle.

## Test plan
- op1 = op2 = 0xFFFFFFFF, each multiply op in turn → MUL 0x00000001, MULH 0x00000000, MULHSU 0xFFFFFFFF, MULHU 0xFFFFFFFE; done in cycle 2 each time.
- DIV/REM with op1 = 0xFFFFFFF9 (−7), op2 = 2 → 0xFFFFFFFD and 0xFFFFFFFF. DIVU/REMU with 100 / 7 → 0x0000000E and 0x00000002. done in cycle 34; stall high cycles 0–33.
- op2 = 0, op1 = 5 → DIV/DIVU 0xFFFFFFFF, REM/REMU 0x00000005. op1 = 0x80000000, op2 = 0xFFFFFFFF → DIV 0x80000000, REM 0. done in cycle 1 with MULDIV_BYPASS_EN, cycle 34 without.
- DIV accepted, flush asserted in cycle 10 → IDLE in cycle 11, no done pulse, result unchanged. A new MUL accepted in cycle 11 → done in cycle 13.
- start held high through a MUL with op changing after acceptance, start asserted in DONE, and start with op = 00000 → only the first op executes, with the latched operands; the other starts are ignored.
- rst asserted in cycle 5 of DIV → next cycle busy = 0, done = 0, result = 0, stall = 0.
